// File: rtl/multicycle_control_if.sv
// Bus between the multicycle datapath and its controller: instruction fields and
// status in, datapath strobes and debug/retire observability out.
interface multicycle_control_if #(
    parameter int CNT_W     = 32,
    parameter int ALUCTRL_W = 3
);
    logic [5:0]           opcode;
    logic [5:0]           funct;
    logic                 zero;
    logic                 mem_ready;
    logic                 pcen;
    logic                 iord;
    logic                 memread;
    logic                 memwrite;
    logic                 irwrite;
    logic                 memtoreg;
    logic                 regdst;
    logic                 regwrite;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic [3:0]           state;
    logic                 instr_done;
    logic                 illegal;
    logic [CNT_W-1:0]     instret;

    modport master (
        output opcode, funct, zero, mem_ready,
        input  pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
        input  alusrca, alusrcb, pcsrc, alucontrol, state, instr_done, illegal, instret
    );

    modport slave (
        input  opcode, funct, zero, mem_ready,
        output pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite,
        output alusrca, alusrcb, pcsrc, alucontrol, state, instr_done, illegal, instret
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-subset datapath with a retired-instruction
// counter. Define CTRL_JUMP_EN to decode opcode 000010 as j; otherwise it is illegal.
module multicycle_control #(
    parameter int CNT_W     = 32,
    parameter int ALUCTRL_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.slave  bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef CTRL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic       pcen, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alu, r_alu;
    logic       r_ok, done, ill;
    logic [ALUCTRL_W-1:0] alu_w;

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (bus.funct)
            6'b100000: r_alu = 3'b010;
            6'b100010: r_alu = 3'b110;
            6'b100100: r_alu = 3'b000;
            6'b100101: r_alu = 3'b001;
            6'b101010: r_alu = 3'b111;
            default:   r_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = FETCH;
        pcen     = 1'b0;  iord     = 1'b0;  memread  = 1'b0;  memwrite = 1'b0;
        irwrite  = 1'b0;  memtoreg = 1'b0;  regdst   = 1'b0;  regwrite = 1'b0;
        alusrca  = 1'b0;  alusrcb  = 2'b00; pcsrc    = 2'b00; alu      = ALU_ADD;
        done     = 1'b0;  ill      = 1'b0;
        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                if (bus.mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     if (r_ok) state_d = EXEC; else ill = 1'b1;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef CTRL_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default:      ill = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                state_d = bus.mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                done     = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                done     = bus.mem_ready;
                state_d  = bus.mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca = 1'b1;
                alu     = r_alu;
                state_d = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                done     = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                alu     = ALU_SUB;
                pcsrc   = 2'b01;
                pcen    = bus.zero;
                done    = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                done     = 1'b1;
            end
`ifdef CTRL_JUMP_EN
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
                done  = 1'b1;
            end
`endif
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        instret_d = instret_q;
        if (done) instret_d = instret_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        alu_w      = '0;
        alu_w[2:0] = alu;
    end

    // Architectural write strobes and pulses are suppressed while reset is held.
    assign bus.pcen       = pcen & rst_n;
    assign bus.irwrite    = irwrite & rst_n;
    assign bus.memwrite   = memwrite & rst_n;
    assign bus.regwrite   = regwrite & rst_n;
    assign bus.instr_done = done & rst_n;
    assign bus.illegal    = ill & rst_n;
    assign bus.iord       = iord;
    assign bus.memread    = memread;
    assign bus.memtoreg   = memtoreg;
    assign bus.regdst     = regdst;
    assign bus.alusrca    = alusrca;
    assign bus.alusrcb    = alusrcb;
    assign bus.pcsrc      = pcsrc;
    assign bus.alucontrol = alu_w;
    assign bus.state      = state_q;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: each issued instruction pushes
// its expected completion record; a negedge monitor checks it when the DUT retires/traps.
module tb_multicycle_control;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if #(.CNT_W(CW), .ALUCTRL_W(3)) bus();
    multicycle_control #(.CNT_W(CW), .ALUCTRL_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        bit          ill;
        int          st;
        int          lat;
        logic [CW-1:0] icnt;
        logic [4:0]  we;     // {pcen, memwrite, regwrite, memtoreg, regdst}
        logic [1:0]  pcsrc;
        logic [2:0]  alu;
        bit          chk_exec;
        logic [2:0]  exec_alu;
    } exp_t;

    exp_t          sb[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [CW-1:0] model_cnt = '0;
    logic [5:0]    fn_tab[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    function automatic bit r_ok(input logic [5:0] f);
        foreach (fn_tab[i]) if (fn_tab[i] == f) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Monitor: per-cycle FETCH/MEMRD strobe checks and scoreboard pop on every event.
    int         cyc_in = 0;
    logic [2:0] exec_seen = 3'b0;
    exp_t       e_m;
    always @(negedge clk) begin
        if (!rst_n) begin
            cyc_in = 0;
        end else begin
            if (bus.state == 4'd0) begin
                chk("fetch_irwrite", {bus.irwrite, bus.pcen}, {bus.mem_ready, bus.mem_ready});
                chk("fetch_mem", {bus.memread, bus.iord, bus.alusrcb}, 4'b1001);
            end
            if (bus.state == 4'd3)
                chk("memrd_ctl", {bus.memread, bus.iord, bus.memwrite, bus.regwrite}, 4'b1100);
            if (bus.state == 4'd6) exec_seen = bus.alucontrol;
            if (bus.instr_done || bus.illegal) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: state %0d with empty scoreboard", bus.state);
                end else begin
                    e_m = sb.pop_front();
                    chk("event_kind", {bus.illegal, bus.instr_done}, {e_m.ill, !e_m.ill});
                    chk("event_state", bus.state, e_m.st);
                    chk("latency", cyc_in + 1, e_m.lat);
                    chk("instret", bus.instret, e_m.icnt);
                    chk("write_en", {bus.pcen, bus.memwrite, bus.regwrite, bus.memtoreg, bus.regdst}, e_m.we);
                    chk("pcsrc", bus.pcsrc, e_m.pcsrc);
                    chk("alu_final", bus.alucontrol, e_m.alu);
                    if (e_m.chk_exec) chk("alu_exec", exec_seen, e_m.exec_alu);
                end
                cyc_in = 0;
            end else begin
                cyc_in++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction starting in FETCH: s1 fetch stall cycles, s2 memory stall cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int s1, input int s2);
        exp_t e;
        bit   memop = 1'b0;
        int   m0 = s1 + 3;
        e.ill = 1'b0; e.pcsrc = 2'b00; e.alu = 3'b010; e.chk_exec = 1'b0; e.exec_alu = 3'b0;
        e.we = 5'b0;
        case (op)
            6'b100011: begin e.st = 4;  e.lat = 5 + s1 + s2; e.we = 5'b00110; memop = 1'b1; end
            6'b101011: begin e.st = 5;  e.lat = 4 + s1 + s2; e.we = 5'b01000; memop = 1'b1; end
            6'b000000: begin
                if (r_ok(fn)) begin
                    e.st = 7; e.lat = 4 + s1; e.we = 5'b00101;
                    e.chk_exec = 1'b1; e.exec_alu = r_alu(fn);
                end else begin
                    e.ill = 1'b1;
                end
            end
            6'b000100: begin e.st = 8;  e.lat = 3 + s1; e.we = {z, 4'b0}; e.pcsrc = 2'b01; e.alu = 3'b110; end
            6'b001000: begin e.st = 10; e.lat = 4 + s1; e.we = 5'b00100; end
`ifdef CTRL_JUMP_EN
            6'b000010: begin e.st = 11; e.lat = 3 + s1; e.we = 5'b10000; e.pcsrc = 2'b10; end
`endif
            default:   e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.st = 1; e.lat = s1 + 2; e.we = 5'b0; memop = 1'b0;
        end
        e.icnt = model_cnt;
        if (!e.ill) model_cnt = model_cnt + 1'b1;
        sb.push_back(e);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        for (int c = 0; c < e.lat; c++) begin
            if (c <= s1)                               bus.mem_ready = (c == s1);
            else if (memop && c >= m0 && c <= m0 + s2) bus.mem_ready = (c == m0 + s2);
            else                                       bus.mem_ready = 1'($urandom_range(0, 1));
            step();
        end
    endtask

    initial begin
        logic [5:0] op, fn;
        bus.opcode = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_state", bus.state, 4'd0);
        chk("rst_instret", bus.instret, '0);
        chk("rst_strobes", {bus.pcen, bus.irwrite, bus.memwrite, bus.regwrite, bus.instr_done, bus.illegal}, 6'b0);
        step();
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);   // add
        run_instr(6'b100011, 6'b000000, 1'b0, 1, 3);   // lw, MEMRD stalled 3 cycles
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // illegal opcode
        run_instr(6'b000000, 6'b000111, 1'b0, 0, 0);   // illegal funct
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // j
        run_instr(6'b101011, 6'b000000, 1'b0, 2, 1);   // sw
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);   // addi

        // Reset while sw is stalled in MEMWR.
        bus.opcode = 6'b101011; bus.mem_ready = 1'b1;
        step(); step(); step();
        bus.mem_ready = 1'b0;
        step();
        @(negedge clk);
        chk("memwr_reached", {bus.state, bus.memwrite}, {4'd5, 1'b1});
        step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_memwrite", {bus.memwrite, bus.instr_done}, 2'b00);
        step();
        chk("rst_abort_state", bus.state, 4'd0);
        chk("rst_abort_instret", bus.instret, '0);
        model_cnt = '0;
        rst_n = 1'b1;

        // Bring instret to all-ones, then addi wraps it to zero.
        for (int i = 0; i < (1 << CW) - 1; i++) run_instr(6'b000100, 6'b0, 1'b0, 0, 0);
        chk("preset_ones", bus.instret, {CW{1'b1}});
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);
        chk("wrap", bus.instret, model_cnt);

        for (int i = 0; i < 300; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin op = 6'b000000; fn = fn_tab[$urandom_range(0, 4)]; end
                3: op = 6'b000000;
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: op = 6'($urandom);
            endcase
            run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        bus.mem_ready = 1'b0;
        repeat (3) step();
        chk("drain", sb.size(), 0);
        chk("final_instret", bus.instret, model_cnt);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
